muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair read by mfhi/mflo.
- Sits beside the EX-stage ALU. The decoder raises `start` with an op code for mult/multu/div/divu.
- Runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, then commits HI/LO.
- Produces the pipeline stall request whenever a HI/LO consumer or a second start meets a busy unit.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EX-stage request to begin an operation.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- src_a  in  WIDTH  rs value (multiplicand / dividend).
- src_b  in  WIDTH  rt value (multiplier / divisor).
- hilo_rd  in  1  mfhi or mflo currently in EX.
- flush  in  1  abort the in-flight operation.
- busy  out  1  high in CALC or SIGN.
- stall  out  1  freeze request to the pipeline.
- done  out  1  one-cycle pulse after HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, count=0, hi=0, lo=0, busy=0, done=0.
  - Any in-flight operation is abandoned; it overrides all other inputs.
- States: IDLE, CALC, SIGN.
- IDLE:
  - On an edge with start=1 and flush=0: latch op and operands, go to CALC, count=0.
  - Signed ops latch magnitudes |src_a| and |src_b|. Also latch neg_q = sign(a)^sign(b) and neg_r = sign(a).
  - 0x80000000 is kept as unsigned 2^31; no overflow special-case.
- CALC:
  - Each edge performs one iteration and increments count.
  - At the edge where count==WIDTH-1, the last (WIDTH-th) iteration completes and the state goes to SIGN.
  - Multiply iteration: 2*WIDTH-bit accumulator, add-and-shift on the multiplier LSB.
  - Divide iteration: restoring; shift the remainder left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- SIGN (one cycle); at its edge:
  - mult: {hi,lo} = neg_q ? -product : product. multu: unsigned product.
  - div: lo = neg_q ? -q : q; hi = neg_r ? -r : r. divu: unsigned.
  - Divisor zero, either div op: lo = all ones, hi = src_a as latched (raw, unsigned). No trap.
  - -2^31 / -1: lo = 0x80000000, hi = 0 (natural wrap).
  - Then state goes to IDLE and done=1 for exactly the following cycle.
- Latency: start sampled at edge T; HI/LO updated at edge T+WIDTH+1 (T+33 by default); done high during cycle T+33..T+34.
- busy = (state != IDLE); combinational from state.
- stall = busy & (start | hilo_rd); combinational.
  - When stall drops in the cycle after the SIGN edge, mfhi/mflo read the new values with no bypass needed.
  - An ignored start is held by the stalled pipeline and is accepted on the first IDLE edge.
- start while busy is never accepted; hi/lo are unchanged except at the SIGN edge.
- flush:
  - In CALC or SIGN: return to IDLE at that edge; hi/lo unchanged; no done.
  - flush with start in IDLE: start is ignored.
- hi/lo hold their value at all other times. No mthi/mtlo path in this block.

Test Plan:
- rst, then multu 0xFFFFFFFF x 0xFFFFFFFF -> busy high for 33 cycles; at T+33 hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064. div 0x80000000 / -1 -> lo=0x80000000, hi=0.
- hilo_rd=1 held from T+1 -> stall=1 through T+33, 0 at T+34. A second start at T+5 is ignored until IDLE, then begins at T+34.
- flush at T+10 with HI/LO preloaded 0x11/0x22 -> IDLE next cycle, hi=0x11, lo=0x22, no done. rst at T+20 -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide sequencer.
// The pipeline (master) issues requests and reads HI/LO.
// The sequencer (slave) answers with busy/stall/done and the register pair.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hilo_rd;
    logic             flush;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hilo_rd, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hilo_rd, flush,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative mult/multu/div/divu unit that owns the HI/LO pair.
// It runs a radix-2 shift-add multiply or a restoring divide on operand
// magnitudes over WIDTH cycles. A single SIGN cycle then applies the result
// signs and commits HI/LO.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; HI/LO hold the last committed result
// CALC  | one shift-add / restore iteration per cycle, WIDTH in total
// SIGN  | apply result signs / divide-by-zero value, commit HI/LO
//
// op encoding: bit1 selects divide, bit0 selects unsigned.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic        clk,
    input logic        rst,
    muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         op_q, op_d;
    // Upper half: product high / partial remainder.
    // Lower half: multiplier / dividend shifting out, with quotient bits shifting in.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Dividend exactly as presented; a divide by zero returns it in HI.
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   commit_hi;
    logic [WIDTH-1:0]   commit_lo;

    // Operand conditioning, one iteration step of each algorithm, and the final sign fix-up.
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.src_a[WIDTH-1];
        b_neg     = signed_op & bus.src_b[WIDTH-1];
        // The most negative value negates to itself.
        // Read as unsigned, that is exactly its magnitude.
        a_mag     = a_neg ? -bus.src_a : bus.src_a;
        b_mag     = b_neg ? -bus.src_b : bus.src_b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

        // Remainder stays below the divisor, so shifting it in one bit always fits in WIDTH+1 bits.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

        prod_fix  = neg_quo_q ? -acc_q : acc_q;
        quo_fix   = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        if (op_q[1]) begin
            if (opnd_q == '0) begin
                commit_hi = a_raw_q;
                commit_lo = '1;
            end else begin
                commit_hi = rem_fix;
                commit_lo = quo_fix;
            end
        end else begin
            commit_hi = prod_fix[2*WIDTH-1:WIDTH];
            commit_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Sequencer next state: accept, iterate, commit, or abandon on flush.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d   = S_CALC;
                    count_d   = '0;
                    op_d      = bus.op;
                    a_raw_d   = bus.src_a;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (bus.op[1]) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = op_q[1] ? div_next : mul_next;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = S_SIGN;
                    end
                end
            end
            S_SIGN: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    hi_d   = commit_hi;
                    lo_d   = commit_lo;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation and clears HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // A stalled pipeline holds its start or HI/LO read until the unit returns to IDLE.
    always_comb begin
        bus.busy  = (state_q != S_IDLE);
        bus.stall = bus.busy & (bus.start | bus.hilo_rd);
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: result values, latency, stall, flush and reset.
module tb_muldiv_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and follow it to completion.
    // Checks busy length, done timing and the committed HI/LO values.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        bit early_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start  = 1'b0;
        cyc        = 0;
        early_done = 1'b0;
        while (bus.busy && cyc < 100) begin
            if (bus.done) early_done = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(cyc), 64'd33);
        check({tag, " done_while_busy"}, {63'd0, early_done}, 64'd0);
        check({tag, " done"}, {63'd0, bus.done}, 64'd1);
        check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        @(negedge clk);
        check({tag, " done_pulse_end"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_done;
        int n_busy;

        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.hilo_rd = 1'b0;
        bus.flush   = 1'b0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);
        check("reset hi", {32'd0, bus.hi}, 64'd0);
        check("reset lo", {32'd0, bus.lo}, 64'd0);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset done", {63'd0, bus.done}, 64'd0);
        check("reset stall", {63'd0, bus.stall}, 64'd0);
        rst = 1'b0;

        run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_100d0", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_m7d0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_mind_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

        // Stall: HI/LO read held from T+1, second start raised at T+5 and held until accepted.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'd3;
        bus.src_b = 32'd4;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b1;
        for (int k = 0; k < 34; k++) begin
            if (k == 4) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.src_a = 32'd5;
                bus.src_b = 32'd6;
            end
            #1;
            check($sformatf("stall k=%0d", k), {63'd0, bus.stall}, (k <= 32) ? 64'd1 : 64'd0);
            if (k == 32) check("stall done_before_commit", {63'd0, bus.done}, 64'd0);
            if (k == 33) begin
                check("stall first_done", {63'd0, bus.done}, 64'd1);
                check("stall first_lo", {32'd0, bus.lo}, 64'd12);
                check("stall first_hi", {32'd0, bus.hi}, 64'd0);
            end
            @(negedge clk);
        end
        bus.start   = 1'b0;
        bus.hilo_rd = 1'b0;
        check("stall second_accepted", {63'd0, bus.busy}, 64'd1);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("stall second_latency", 64'(cyc), 64'd33);
        check("stall second_lo", {32'd0, bus.lo}, 64'd30);
        check("stall second_hi", {32'd0, bus.hi}, 64'd0);
        @(negedge clk);

        // Flush mid-calculation with HI/LO preloaded to 0x11/0x22.
        run_op("preload", 2'b01, 32'h8000_0001, 32'h0000_0022, 32'h0000_0011, 32'h0000_0022);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.src_a = 32'hFFFF_FFFF;
        bus.src_b = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {63'd0, bus.busy}, 64'd0);
        check("flush hi", {32'd0, bus.hi}, 64'h11);
        check("flush lo", {32'd0, bus.lo}, 64'h22);
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) n_done++;
            if (bus.busy) n_busy++;
            @(negedge clk);
        end
        check("flush no_done", 64'(n_done), 64'd0);
        check("flush stays_idle", 64'(n_busy), 64'd0);
        check("flush hi_held", {32'd0, bus.hi}, 64'h11);

        // Start together with flush in IDLE is ignored.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("idle_flush busy", {63'd0, bus.busy}, 64'd0);
        check("idle_flush lo", {32'd0, bus.lo}, 64'h22);

        // Reset mid-calculation clears HI/LO and abandons the operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid hi", {32'd0, bus.hi}, 64'd0);
        check("rst_mid lo", {32'd0, bus.lo}, 64'd0);
        check("rst_mid busy", {63'd0, bus.busy}, 64'd0);
        check("rst_mid done", {63'd0, bus.done}, 64'd0);

        run_op("after_rst", 2'b11, 32'd1000, 32'd3, 32'h0000_0001, 32'd333);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
